// File: rtl/fetch_unit.sv
// IF stage: owns the PC, one outstanding imem request, holds the word for IF/ID; best case 1 instr / 3 cycles.
// Backpressure: imem_req_ready=0 keeps the request up; ifIdWrite=0 freezes pc/word in HOLD.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ifIdWrite,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic [31:0] ibuf;
    logic [31:0] ibuf_nxt;
    logic [31:0] redirect_word;

    assign redirect_word = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            pc_q  <= RESET_PC;
            ibuf  <= NOP_INSN;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            ibuf  <= ibuf_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_q;
        ibuf_nxt       = ibuf;
        imem_req_valid = 1'b0;
        fetch_valid    = 1'b0;

        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    ibuf_nxt  = imem_rdata;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                fetch_valid = 1'b1;
                if (ifIdWrite) begin
                    pc_nxt    = pc_q + 32'd4;
                    state_nxt = REQ;
                end
            end
            DROP: begin
                if (imem_rsp_valid) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase

        // A redirect overrides everything above; an already-accepted request still owes its response.
        if (redirect_valid) begin
            pc_nxt   = redirect_word;
            ibuf_nxt = ibuf;
            case (state)
                REQ:        state_nxt = imem_req_ready ? DROP : REQ;
                WAIT, DROP: state_nxt = imem_rsp_valid ? REQ : DROP;
                default:    state_nxt = REQ;
            endcase
        end
    end

    assign imem_addr       = pc_q;
    assign pc_out          = pc_q;
    assign instruction_out = fetch_valid ? ibuf : NOP_INSN;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against an in-order fetch-stream model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ifIdWrite;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_valid;

    int errors = 0;
    int checks = 0;

    // memory responder controls and state
    bit          mem_auto = 1'b0;
    int          rdy_lo = 0, rdy_hi = 0, rsp_lo = 0, rsp_hi = 0;
    bit          pend = 1'b0, rdy_armed = 1'b0;
    int          pend_cnt = 0, rdy_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    fetch_unit dut (
        .clk             (clk),
        .resetn          (resetn),
        .ifIdWrite       (ifIdWrite),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .fetch_valid     (fetch_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd12) return 32'hA + (a >> 2);
        return {a[15:0], ~a[31:16]};
    endfunction

    // Instruction memory: accepts after a ready delay, answers after a response delay.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_auto) begin
                imem_rsp_valid = 1'b0;
                imem_rdata     = $urandom;
                if (pend) begin
                    if (pend_cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rdata     = mem_word(pend_addr);
                        pend           = 1'b0;
                    end else begin
                        pend_cnt = pend_cnt - 1;
                    end
                end
                imem_req_ready = 1'($urandom_range(1, 0));
                if (imem_req_valid === 1'b1) begin
                    imem_req_ready = 1'b0;
                    if (!rdy_armed) begin
                        rdy_cnt   = int'($urandom_range(rdy_hi, rdy_lo));
                        rdy_armed = 1'b1;
                    end
                    if (rdy_cnt == 0) begin
                        imem_req_ready = 1'b1;
                        rdy_armed      = 1'b0;
                        pend           = 1'b1;
                        pend_addr      = imem_addr;
                        pend_cnt       = int'($urandom_range(rsp_hi, rsp_lo));
                    end else begin
                        rdy_cnt = rdy_cnt - 1;
                    end
                end
            end
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fetch_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetn         = 1'b0;
        ifIdWrite      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || instruction_out !== NOP ||
                pc_out !== 32'h0 || imem_addr !== 32'h0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: req=%b fv=%b insn=%h pc=%h addr=%h, want 0 0 %h 0 0",
                         i, imem_req_valid, fetch_valid, instruction_out, pc_out, imem_addr, NOP);
            end
        end
        resetn         = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_auto       = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h, want 1 00000000", imem_req_valid, imem_addr);
        end
    endtask

    task automatic test_stream;
        int n = 0;
        int last = 0;
        ifIdWrite = 1'b1;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (fetch_valid === 1'b1) begin
                checks++;
                if (pc_out !== 32'(n * 4) || instruction_out !== 32'hA + 32'(n)) begin
                    errors++;
                    $display("FAIL stream_word%0d: pc=%h insn=%h, want %h %h",
                             n, pc_out, instruction_out, 32'(n * 4), 32'hA + 32'(n));
                end
                if (n > 0) begin
                    checks++;
                    if (c - last != 3) begin
                        errors++;
                        $display("FAIL stream_spacing%0d: %0d cycles, want 3", n, c - last);
                    end
                end
                last = c;
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL stream_count: %0d words seen, want 3", n);
        end
    endtask

    task automatic test_stall;
        ifIdWrite = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fetch_valid !== 1'b1 || pc_out !== 32'h8 || instruction_out !== 32'hC ||
                imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_frozen cyc%0d: fv=%b pc=%h insn=%h req=%b, want 1 8 c 0",
                         i, fetch_valid, pc_out, instruction_out, imem_req_valid);
            end
        end
        ifIdWrite = 1'b1;
        @(negedge clk);
        ifIdWrite = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h fv=%b, want 1 0000000c 0",
                     imem_req_valid, imem_addr, fetch_valid);
        end
    endtask

    task automatic test_redirect_wait;
        bit ok;
        int cnt;
        rsp_lo = 4;
        rsp_hi = 4;
        wait_valid(ok);
        checks++;
        if (!ok || pc_out !== 32'hC) begin
            errors++;
            $display("FAIL rdw_setup: ok=%b pc=%h, want 1 0000000c", ok, pc_out);
        end
        ifIdWrite = 1'b1;
        @(negedge clk);
        ifIdWrite = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL rdw_req: req=%b addr=%h, want 1 00000010", imem_req_valid, imem_addr);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        cnt = 1;
        while (imem_req_valid !== 1'b1 && cnt < 50) begin
            checks++;
            if (fetch_valid !== 1'b0) begin
                errors++;
                $display("FAIL rdw_drop_valid: fv=%b pc=%h, want 0", fetch_valid, pc_out);
            end
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != 5 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL rdw_restart: after %0d cycles addr=%h, want 5 cycles 00000200", cnt, imem_addr);
        end
        rsp_lo = 0;
        rsp_hi = 0;
        wait_valid(ok);
        checks++;
        if (!ok || pc_out !== 32'h200 || instruction_out !== mem_word(32'h200)) begin
            errors++;
            $display("FAIL rdw_first: ok=%b pc=%h insn=%h, want 1 00000200 %h",
                     ok, pc_out, instruction_out, mem_word(32'h200));
        end
    endtask

    task automatic test_redirect_same;
        bit ok;
        rsp_lo    = 2;
        rsp_hi    = 2;
        ifIdWrite = 1'b1;
        @(negedge clk);
        ifIdWrite = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h204) begin
            errors++;
            $display("FAIL rds_req: req=%b addr=%h, want 1 00000204", imem_req_valid, imem_addr);
        end
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        ifIdWrite      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        ifIdWrite      = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL rds_discard: fv=%b req=%b addr=%h, want 0 1 00000300",
                     fetch_valid, imem_req_valid, imem_addr);
        end
        wait_valid(ok);
        checks++;
        if (!ok || pc_out !== 32'h300 || instruction_out !== mem_word(32'h300)) begin
            errors++;
            $display("FAIL rds_first: ok=%b pc=%h insn=%h, want 1 00000300 %h",
                     ok, pc_out, instruction_out, mem_word(32'h300));
        end
    endtask

    task automatic test_redirect_hold;
        bit ok;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h401;
        ifIdWrite      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        ifIdWrite      = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h400) begin
            errors++;
            $display("FAIL rdh_target: fv=%b req=%b addr=%h, want 0 1 00000400",
                     fetch_valid, imem_req_valid, imem_addr);
        end
        wait_valid(ok);
        checks++;
        if (!ok || pc_out !== 32'h400 || instruction_out !== mem_word(32'h400)) begin
            errors++;
            $display("FAIL rdh_first: ok=%b pc=%h insn=%h, want 1 00000400 %h",
                     ok, pc_out, instruction_out, mem_word(32'h400));
        end
    endtask

    task automatic test_wrap;
        bit ok;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req: req=%b addr=%h, want 1 fffffffc", imem_req_valid, imem_addr);
        end
        wait_valid(ok);
        checks++;
        if (!ok || pc_out !== 32'hFFFF_FFFC || instruction_out !== mem_word(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_word: ok=%b pc=%h insn=%h, want 1 fffffffc %h",
                     ok, pc_out, instruction_out, mem_word(32'hFFFF_FFFC));
        end
        ifIdWrite = 1'b1;
        @(negedge clk);
        ifIdWrite = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: req=%b addr=%h, want 1 00000000", imem_req_valid, imem_addr);
        end
    endtask

    // Model: IF/ID must see the program stream pc, pc+4, ... restarting at each redirect target.
    task automatic test_random;
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] tgt;
        int          consumed = 0;
        bit          rd, wr;
        rdy_lo = 0;
        rdy_hi = 7;
        rsp_lo = 0;
        rsp_hi = 7;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            checks++;
            if (fetch_valid === 1'b1) begin
                if (pc_out !== exp_pc || instruction_out !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL rand_word cyc%0d: pc=%h insn=%h, want %h %h",
                             c, pc_out, instruction_out, exp_pc, mem_word(exp_pc));
                end
            end else if (instruction_out !== NOP) begin
                errors++;
                $display("FAIL rand_bubble cyc%0d: insn=%h, want %h", c, instruction_out, NOP);
            end
            rd  = ($urandom_range(31, 0) == 0);
            wr  = ($urandom_range(3, 0) != 0);
            tgt = $urandom;
            if (rd) begin
                exp_pc = tgt & 32'hFFFF_FFFC;
            end else if (fetch_valid === 1'b1 && wr) begin
                exp_pc   = exp_pc + 32'd4;
                consumed = consumed + 1;
            end
            redirect_valid = rd;
            redirect_pc    = tgt;
            ifIdWrite      = wr;
        end
        redirect_valid = 1'b0;
        ifIdWrite      = 1'b0;
        checks++;
        if (consumed < 50) begin
            errors++;
            $display("FAIL rand_progress: %0d instructions delivered, want at least 50", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_same();
        test_redirect_hold();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
